seq_pattern_detector: RTL and testbench
=======================================

Name: seq_pattern_detector

Overview:
Parametrised serial pattern detector, the successor to the fixed-pattern detector. Samples a 1-bit stream qualified by a valid strobe and matches a runtime-loadable pattern of 1..MAX_LEN bits. Supports overlapping and non-overlapping match modes and counts matches in a saturating counter. Sits between the serial front end and the status/interrupt logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of length fields; must hold MAX_LEN
CNT_W, 8, match counter width
DEFAULT_PATTERN, 8'b0000_1011, pattern loaded at reset (MAX_LEN bits, right-aligned)
DEFAULT_LEN, 4, pattern length loaded at reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
cfg_load  input  1  load cfg_pattern/cfg_len this cycle
cfg_pattern  input  MAX_LEN  new pattern, right-aligned; bit[len-1] is the first bit expected
cfg_len  input  LEN_W  new pattern length
overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping; sampled every cycle
in_valid  input  1  stream_in is valid this cycle
stream_in  input  1  serial data bit, MSB of pattern first
cnt_clr  input  1  synchronous clear of match_count and count_sat
pattern_found  output  1  one-cycle pulse, registered
match_count  output  CNT_W  number of matches since reset/clear, saturating
count_sat  output  1  sticky; set when match_count reaches all-ones
cfg_err  output  1  one-cycle pulse, registered: rejected cfg_load

Behaviour:
- Reset (async, active-high): history=0, fill=0, pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, pattern_found=0, match_count=0, count_sat=0, cfg_err=0. All state holds while rst is high.
- History: MAX_LEN-bit shift register; on an accepted bit: hist <= {hist[MAX_LEN-2:0], stream_in}, fill <= min(fill+1, MAX_LEN).
- Match condition on an accepted bit: (fill_next >= len) and hist_next[len-1:0] == pattern[len-1:0]. Bits above len are ignored.
- Latency: pattern_found goes high in the cycle after the completing bit is sampled, for exactly one cycle. It is 0 in every cycle with no match, including cycles where in_valid is 0.
- in_valid=0: history, fill and pattern_found stay unchanged, except that pattern_found deasserts.
- Overlap mode (overlap_en=1): fill is unaffected by a match; suffix bits count toward the next match.
- Non-overlap mode (overlap_en=0): on a match, fill <= 0. The next match needs len fresh bits.
- cfg_load:
  - Accepted when 1 <= cfg_len <= MAX_LEN. Latches pattern and len, clears history and fill, and causes no pattern_found that cycle.
  - Otherwise rejected: configuration unchanged, history untouched, cfg_err pulses in the next cycle.
  - cfg_load with in_valid in the same cycle: cfg_load wins and the stream bit is discarded.
- match_count: increments by 1 on each match, registered together with pattern_found. It holds at all-ones, and count_sat sets in the same cycle the count reaches all-ones.
- cnt_clr: clears match_count and count_sat. If a match occurs in the same cycle, the result is match_count=1 (clear then count).
- Mode switch mid-stream: takes effect on the next accepted bit. Fill is not retroactively changed.

Test Plan:
- Default config (1011, len 4), overlap_en=1, stream 00011010111101011011 MSB-first, in_valid=1 -> pattern_found pulses the cycle after bits 10, 17 and 20; match_count=3.
- Same stream, overlap_en=0 -> pulses only after bits 10 and 17; match_count=2.
- cfg_load pattern 101, len 3; stream 10101 -> overlap: pulses after bits 3 and 5 (count 2); non-overlap: pulse after bit 3 only (count 1).
- Stream 1,0,1,1 with in_valid deasserted for 3 cycles between each bit -> exactly one pulse, one cycle after the final 1; no pulse during gaps.
- cfg_load with cfg_len=0, then with cfg_len=9 -> cfg_err pulses each time and config stays 1011/4. cfg_load and in_valid in the same cycle -> bit dropped, fill=0.
- Overrides CNT_W=4, pattern 1 len 1; 20 ones -> match_count=15, count_sat=1. Then cnt_clr -> 0/0.
- Async reset after 1,0,1, then send 1 -> no pulse; match_count=0; pattern restored to 1011/4.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: matches a runtime-loadable pattern of 1..MAX_LEN bits
// against a valid-qualified bit stream and counts matches in a saturating counter.
module seq_pattern_detector #(
   parameter int                 MAX_LEN         = 8,
   parameter int                 LEN_W           = 4,
   parameter int                 CNT_W           = 8,
   parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1011,
   parameter logic [LEN_W-1:0]   DEFAULT_LEN     = 4'd4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               overlap_en,
   input  logic               in_valid,
   input  logic               stream_in,
   input  logic               cnt_clr,
   output logic               pattern_found,
   output logic [CNT_W-1:0]   match_count,
   output logic               count_sat,
   output logic               cfg_err
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] pattern;
   logic [MAX_LEN-1:0] hist_next;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W-1:0]   fill;
   logic [LEN_W-1:0]   len;
   logic [LEN_W-1:0]   fill_next;
   logic               cfg_ok;
   logic               accept;
   logic               match_hit;
   logic [CNT_W-1:0]   cnt_base;
   logic [CNT_W-1:0]   cnt_next;
   logic               sat_base;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      cfg_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
      // A cfg_load cycle always discards the stream bit, even when the load is rejected.
      accept    = in_valid && !cfg_load;
      hist_next = {hist[MAX_LEN-2:0], stream_in};
      fill_next = (fill == MAX_LEN_L) ? fill : fill + 1'b1;

      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len));
      end

      match_hit = accept && (fill_next >= len) &&
                  (((hist_next ^ pattern) & len_mask) == '0);

      // Clear is applied first, then a coincident match counts on top of it.
      cnt_base = cnt_clr ? '0 : match_count;
      sat_base = cnt_clr ? 1'b0 : count_sat;
      cnt_next = cnt_base;
      if (match_hit && (cnt_base != CNT_MAX)) begin
         cnt_next = cnt_base + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist          <= '0;
         fill          <= '0;
         pattern       <= DEFAULT_PATTERN;
         len           <= DEFAULT_LEN;
         pattern_found <= 1'b0;
         match_count   <= '0;
         count_sat     <= 1'b0;
         cfg_err       <= 1'b0;
      end else begin
         pattern_found <= match_hit;
         cfg_err       <= cfg_load && !cfg_ok;
         match_count   <= cnt_next;
         count_sat     <= sat_base || (cnt_next == CNT_MAX);

         if (cfg_load) begin
            if (cfg_ok) begin
               pattern <= cfg_pattern;
               len     <= cfg_len;
               hist    <= '0;
               fill    <= '0;
            end
         end else if (accept) begin
            hist <= hist_next;
            // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
            fill <= (match_hit && !overlap_en) ? '0 : fill_next;
         end
      end
   end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Table-driven bench for seq_pattern_detector with a scoreboard queue; a second
// instance with a 4-bit counter covers saturation.
module tb_seq_pattern_detector;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       overlap_en;
   logic       in_valid;
   logic       stream_in;
   logic       cnt_clr;

   logic       pattern_found;
   logic [7:0] match_count;
   logic       count_sat;
   logic       cfg_err;
   logic       pattern_found4;
   logic [3:0] match_count4;
   logic       count_sat4;
   logic       cfg_err4;

   seq_pattern_detector dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .overlap_en(overlap_en), .in_valid(in_valid),
      .stream_in(stream_in), .cnt_clr(cnt_clr), .pattern_found(pattern_found),
      .match_count(match_count), .count_sat(count_sat), .cfg_err(cfg_err)
   );

   seq_pattern_detector #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .overlap_en(overlap_en), .in_valid(in_valid),
      .stream_in(stream_in), .cnt_clr(cnt_clr), .pattern_found(pattern_found4),
      .match_count(match_count4), .count_sat(count_sat4), .cfg_err(cfg_err4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       cfg_load;
      logic [7:0] cfg_pattern;
      logic [3:0] cfg_len;
      logic       overlap_en;
      logic       in_valid;
      logic       stream_in;
      logic       cnt_clr;
      logic       exp_found;
      logic       exp_err;
      logic [7:0] exp_cnt;
      string      tag;
   } vec_t;

   typedef struct {
      logic       found;
      logic       err;
      logic       sat;
      logic [7:0] cnt;
      logic [3:0] cnt4;
      logic       sat4;
      string      tag;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   run_cnt  = 0;
   logic cur_ov   = 1'b1;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add_vec(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                                   input logic vld, input logic bit_in, input logic clr,
                                   input logic found, input logic err, input string tag);
      vec_t v;
      if (clr) run_cnt = 0;
      if (found) run_cnt++;
      v.cfg_load    = ld;
      v.cfg_pattern = pat;
      v.cfg_len     = len;
      v.overlap_en  = cur_ov;
      v.in_valid    = vld;
      v.stream_in   = bit_in;
      v.cnt_clr     = clr;
      v.exp_found   = found;
      v.exp_err     = err;
      v.exp_cnt     = 8'(run_cnt);
      v.tag         = tag;
      vecs.push_back(v);
   endfunction

   // bits and hits are MSB-first: bit n-1 is sent first, hits marks the expected pulses.
   function automatic void add_bits(input logic [31:0] bits, input logic [31:0] hits,
                                    input int n, input string tag);
      for (int i = n - 1; i >= 0; i--) begin
         add_vec(1'b0, 8'h00, 4'd0, 1'b1, bits[i], 1'b0, hits[i], 1'b0,
                 $sformatf("%s[%0d]", tag, n - i));
      end
   endfunction

   function automatic void add_idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         add_vec(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
      end
   endfunction

   function automatic void add_cfg(input logic [7:0] pat, input logic [3:0] len,
                                   input logic clr, input string tag);
      add_vec(1'b1, pat, len, 1'b0, 1'b0, clr, 1'b0, 1'b0, tag);
   endfunction

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         return;
      end
      e = sb.pop_front();
      check({e.tag, " found"}, 8'(pattern_found), 8'(e.found));
      check({e.tag, " count"}, match_count, e.cnt);
      check({e.tag, " sat"}, 8'(count_sat), 8'(e.sat));
      check({e.tag, " err"}, 8'(cfg_err), 8'(e.err));
      check({e.tag, " found4"}, 8'(pattern_found4), 8'(e.found));
      check({e.tag, " err4"}, 8'(cfg_err4), 8'(e.err));
      check({e.tag, " count4"}, 8'(match_count4), 8'(e.cnt4));
      check({e.tag, " sat4"}, 8'(count_sat4), 8'(e.sat4));
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      cfg_load    = v.cfg_load;
      cfg_pattern = v.cfg_pattern;
      cfg_len     = v.cfg_len;
      overlap_en  = v.overlap_en;
      in_valid    = v.in_valid;
      stream_in   = v.stream_in;
      cnt_clr     = v.cnt_clr;
      e.found = v.exp_found;
      e.err   = v.exp_err;
      e.cnt   = v.exp_cnt;
      e.sat   = (v.exp_cnt == 8'hFF);
      e.cnt4  = (v.exp_cnt > 8'd15) ? 4'hF : v.exp_cnt[3:0];
      e.sat4  = (v.exp_cnt >= 8'd15);
      e.tag   = v.tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " found"}, 8'(pattern_found), 8'h00);
      check({tag, " count"}, match_count, 8'h00);
      check({tag, " sat"}, 8'(count_sat), 8'h00);
      check({tag, " err"}, 8'(cfg_err), 8'h00);
      check({tag, " count4"}, 8'(match_count4), 8'h00);
      check({tag, " sat4"}, 8'(count_sat4), 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      cfg_load    = 1'b0;
      cfg_pattern = 8'h00;
      cfg_len     = 4'd0;
      overlap_en  = 1'b1;
      in_valid    = 1'b0;
      stream_in   = 1'b0;
      cnt_clr     = 1'b0;

      cur_ov = 1'b1;
      add_bits(32'b00011010111101011011, 32'b00000000010000001001, 20, "ov_default");
      add_cfg(8'b1011, 4'd4, 1'b1, "reload_clr");
      cur_ov = 1'b0;
      add_bits(32'b00011010111101011011, 32'b00000000010000001000, 20, "nonov_default");
      cur_ov = 1'b1;
      add_cfg(8'b101, 4'd3, 1'b1, "cfg_101_ov");
      add_bits(32'b10101, 32'b00101, 5, "ov_101");
      cur_ov = 1'b0;
      add_cfg(8'b101, 4'd3, 1'b1, "cfg_101_nonov");
      add_bits(32'b10101, 32'b00100, 5, "nonov_101");
      cur_ov = 1'b1;
      add_cfg(8'b1011, 4'd4, 1'b1, "cfg_gap");
      add_bits(32'b1, 32'b0, 1, "gap_b1");
      add_idle(3, "gap_idle1");
      add_bits(32'b0, 32'b0, 1, "gap_b2");
      add_idle(3, "gap_idle2");
      add_bits(32'b1, 32'b0, 1, "gap_b3");
      add_idle(3, "gap_idle3");
      add_bits(32'b1, 32'b1, 1, "gap_b4");
      add_idle(1, "gap_after");
      add_vec(1'b1, 8'hFF, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "bad_len0");
      add_vec(1'b1, 8'h00, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "bad_len9");
      add_idle(1, "err_gone");
      add_bits(32'b1011, 32'b0001, 4, "after_reject");
      add_cfg(8'b11001010, 4'd8, 1'b1, "cfg_len8");
      add_bits(32'b11001010, 32'b00000001, 8, "len8");
      add_vec(1'b1, 8'b1011, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "cfg_and_valid");
      add_bits(32'b011, 32'b000, 3, "dropped_bit");
      add_cfg(8'b1, 4'd1, 1'b1, "cfg_sat");
      add_bits(32'hFFFFF, 32'hFFFFF, 20, "sat");
      add_vec(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "clr");
      add_vec(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "clr_and_match");

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      foreach (vecs[i]) apply(vecs[i]);

      // Async reset mid-stream after a non-default config.
      vecs.delete();
      add_cfg(8'b101, 4'd3, 1'b0, "pre_rst_cfg");
      add_bits(32'b101, 32'b001, 3, "pre_rst");
      foreach (vecs[i]) apply(vecs[i]);

      rst = 1'b1;
      #2;
      check_all_zero("async_rst");
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
      rst     = 1'b0;
      run_cnt = 0;

      vecs.delete();
      add_bits(32'b1, 32'b0, 1, "post_rst_first");
      add_bits(32'b011, 32'b001, 3, "post_rst_1011");
      foreach (vecs[i]) apply(vecs[i]);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
